interrupt_ack_sequencer: RTL and testbench
==========================================

INTERRUPT_ACK_SEQUENCER -- requirements
Module: interrupt_ack_sequencer

Interface
REQ-001 Parameter: AUTO_EOI, 0, when 1 the ISR bit of the serviced request clears automatically at the second acknowledge.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 irr  input  8  pending interrupt requests (level), bit 0 highest priority.
REQ-005 imr  input  8  interrupt mask, 1 = masked.
REQ-006 inta  input  1  acknowledge strobe, one-cycle active-high pulse per acknowledge.
REQ-007 eoi  input  1  end-of-interrupt command strobe, one cycle.
REQ-008 eoi_specific  input  1  qualifies eoi: 1 = specific, 0 = non-specific.
REQ-009 eoi_level  input  3  ISR bit index cleared by a specific EOI.
REQ-010 vector_base  input  5  upper five bits of the returned vector.
REQ-011 int_out  output  1  interrupt request to the CPU.
REQ-012 clear_irr  output  8  one-hot, one-cycle pulse clearing the acknowledged request bit.
REQ-013 isr  output  8  in-service register.
REQ-014 vector  output  8  interrupt vector, {vector_base, index}.
REQ-015 vector_valid  output  1  one-cycle pulse, vector is valid.

Function
REQ-016 Eligible request i: irr[i]=1, imr[i]=0, and no isr[j]=1 for any j<=i (fully nested; equal or lower priority blocked).
REQ-017 Winner: lowest-index eligible request, resolved combinationally each cycle.
REQ-018 FSM states: IDLE, PEND, ACK1; int_out SHALL be 1 exactly while state = PEND.
REQ-019 IDLE -> PEND on an edge where an eligible request exists; int_out therefore rises one cycle after the request is presented.
REQ-020 inta in IDLE or extra pulses outside PEND/ACK1 SHALL be ignored.
REQ-021 PEND, no inta, no eligible request -> IDLE (request withdrawn; int_out drops next cycle).
REQ-022 PEND + inta with winner w -> ACK1: latch index w, set isr[w], clear_irr = one-hot(w) for one cycle.
REQ-023 PEND + inta with no eligible request (spurious): latch index 7, no ISR bit set, clear_irr stays 0, -> ACK1.
REQ-024 ACK1 + inta -> IDLE: next cycle vector = {vector_base, latched index}, vector_valid = 1 for one cycle; vector holds its value until the next acknowledge.
REQ-025 ACK1 without inta SHALL wait indefinitely; new requests do not alter the latched index.
REQ-026 AUTO_EOI=1: the second inta clears isr[latched index] (no clear for a spurious acknowledge).
REQ-027 Non-specific eoi clears the lowest-index set ISR bit; no effect when isr = 0.
REQ-028 Specific eoi clears isr[eoi_level]; no effect if that bit is already 0.
REQ-029 EOI is evaluated against ISR before the same-cycle update; if set and clear target the same bit in one cycle, set wins.
REQ-030 The ISR change caused by EOI is visible to eligibility from the next cycle, allowing an IDLE -> PEND transition then.
REQ-031 Higher-priority requests arriving while isr is non-zero SHALL nest (new PEND cycle), and the lower one stays in service.

Reset
REQ-032 rst_n low, at any time, immediately forces: state IDLE, int_out 0, isr 0, clear_irr 0, vector 0, vector_valid 0, latched index 0.
REQ-033 Reset mid-acknowledge (PEND or ACK1) abandons the sequence; no vector_valid is issued after reset release.

Verification
REQ-034 irr=0x08, imr=0x00 at cycle 0 -> int_out=1 at cycle 1; inta -> isr=0x08, clear_irr=0x08 one cycle; second inta with vector_base=0x01 -> vector=0x0B, vector_valid pulse.
REQ-035 irr=0x24, imr=0x04 -> winner 5; after two inta pulses isr=0x20, vector low bits=3'd5.
REQ-036 isr=0x08 in service, irr=0x02 -> nests: isr=0x0A after first inta; irr=0x10 instead -> int_out stays 0; non-specific eoi then clears bit 1, then bit 3.
REQ-037 irr=0x01 withdrawn in the same cycle as the first inta -> isr unchanged, clear_irr=0, vector low bits=3'd7.
REQ-038 AUTO_EOI=1, irr=0x40 acknowledged twice -> isr=0x40 between pulses, 0x00 after the second; specific eoi with eoi_level=2 on isr=0x04 -> isr=0x00.
REQ-039 rst_n pulsed low while in ACK1 -> all outputs 0 immediately, no vector_valid afterwards.

Source files
------------

// File: rtl/interrupt_ack_sequencer.sv
// Priority interrupt controller acknowledge sequencer: fully nested priority,
// two-pulse acknowledge handshake, in-service tracking and EOI handling.
module interrupt_ack_sequencer #(
    parameter bit AUTO_EOI = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic       inta,
    input  logic       eoi,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic [4:0] vector_base,
    output logic       int_out,
    output logic [7:0] clear_irr,
    output logic [7:0] isr,
    output logic [7:0] vector,
    output logic       vector_valid
);

    typedef enum logic [1:0] {IDLE, PEND, ACK1} state_t;

    state_t     state_q, state_d;
    logic       int_out_q, int_out_d;
    logic [7:0] clear_irr_q, clear_irr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] vector_q, vector_d;
    logic       vector_valid_q, vector_valid_d;
    logic [2:0] idx_q, idx_d;
    logic       spurious_q, spurious_d;

    logic [7:0] eligible;
    logic       blocked;
    logic       any_elig;
    logic [2:0] winner;
    logic [7:0] eoi_clr;
    logic [7:0] auto_clr;
    logic [7:0] isr_set;

    // A request is blocked by any in-service bit of equal or higher priority.
    always_comb begin
        eligible = '0;
        blocked  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            blocked     = blocked | isr_q[i];
            eligible[i] = irr[i] & ~imr[i] & ~blocked;
        end
        any_elig = 1'b0;
        winner   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) begin
                any_elig = 1'b1;
                winner   = i[2:0];
            end
        end
    end

    always_comb begin
        eoi_clr = '0;
        if (eoi) begin
            if (eoi_specific) eoi_clr[eoi_level] = 1'b1;
            else              eoi_clr = isr_q & (~isr_q + 8'd1);
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        spurious_d     = spurious_q;
        isr_set        = '0;
        auto_clr       = '0;
        clear_irr_d    = '0;
        vector_d       = vector_q;
        vector_valid_d = 1'b0;
        case (state_q)
            IDLE: if (any_elig) state_d = PEND;
            PEND: begin
                if (inta) begin
                    state_d = ACK1;
                    if (any_elig) begin
                        idx_d       = winner;
                        spurious_d  = 1'b0;
                        isr_set     = 8'b1 << winner;
                        clear_irr_d = 8'b1 << winner;
                    end else begin
                        idx_d      = 3'd7;
                        spurious_d = 1'b1;
                    end
                end else if (!any_elig) begin
                    state_d = IDLE;
                end
            end
            ACK1: begin
                if (inta) begin
                    state_d        = IDLE;
                    vector_d       = {vector_base, idx_q};
                    vector_valid_d = 1'b1;
                    if (AUTO_EOI && !spurious_q) auto_clr = 8'b1 << idx_q;
                end
            end
            default: state_d = IDLE;
        endcase
        // Clears apply to the pre-update ISR; a same-cycle set overrides them.
        isr_d     = (isr_q & ~(eoi_clr | auto_clr)) | isr_set;
        int_out_d = (state_d == PEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            int_out_q      <= 1'b0;
            clear_irr_q    <= '0;
            isr_q          <= '0;
            vector_q       <= '0;
            vector_valid_q <= 1'b0;
            idx_q          <= '0;
            spurious_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            int_out_q      <= int_out_d;
            clear_irr_q    <= clear_irr_d;
            isr_q          <= isr_d;
            vector_q       <= vector_d;
            vector_valid_q <= vector_valid_d;
            idx_q          <= idx_d;
            spurious_q     <= spurious_d;
        end
    end

    assign int_out      = int_out_q;
    assign clear_irr    = clear_irr_q;
    assign isr          = isr_q;
    assign vector       = vector_q;
    assign vector_valid = vector_valid_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Self-checking bench: vector table with scoreboard queue for the nested-mode
// instance, plus hand sequences for reset mid-acknowledge and auto-EOI.
module tb_interrupt_ack_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irr = '0, imr = '0;
    logic       inta = 1'b0, eoi = 1'b0, eoi_specific = 1'b0;
    logic [2:0] eoi_level = '0;
    logic [4:0] vector_base = '0;

    logic       int_out0, vv0, int_out1, vv1;
    logic [7:0] clr0, isr0, vec0, clr1, isr1, vec1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    interrupt_ack_sequencer #(.AUTO_EOI(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .inta(inta), .eoi(eoi),
        .eoi_specific(eoi_specific), .eoi_level(eoi_level), .vector_base(vector_base),
        .int_out(int_out0), .clear_irr(clr0), .isr(isr0), .vector(vec0), .vector_valid(vv0));

    interrupt_ack_sequencer #(.AUTO_EOI(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .inta(inta), .eoi(eoi),
        .eoi_specific(eoi_specific), .eoi_level(eoi_level), .vector_base(vector_base),
        .int_out(int_out1), .clear_irr(clr1), .isr(isr1), .vector(vec1), .vector_valid(vv1));

    typedef struct {
        logic [7:0] irr, imr;
        logic       inta, eoi, esp;
        logic [2:0] elev;
        logic [4:0] vb;
        logic       e_int;
        logic [7:0] e_clr, e_isr, e_vec;
        logic       e_vv;
    } vec_t;

    typedef struct {
        int         tag;
        logic       e_int;
        logic [7:0] e_clr, e_isr, e_vec;
        logic       e_vv;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic chk(input string name, input int tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, tag, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] i_irr, input logic [7:0] i_imr, input logic i_inta,
                         input logic i_eoi, input logic i_esp, input logic [2:0] i_elev,
                         input logic [4:0] i_vb);
        irr = i_irr; imr = i_imr; inta = i_inta; eoi = i_eoi;
        eoi_specific = i_esp; eoi_level = i_elev; vector_base = i_vb;
    endtask

    // Advance one clock and compare dut0 against the oldest scoreboard entry.
    task automatic clock_and_score();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
        end else begin
            e = sb.pop_front();
            chk("int_out",      e.tag, {7'd0, int_out0}, {7'd0, e.e_int});
            chk("clear_irr",    e.tag, clr0, e.e_clr);
            chk("isr",          e.tag, isr0, e.e_isr);
            chk("vector",       e.tag, vec0, e.e_vec);
            chk("vector_valid", e.tag, {7'd0, vv0}, {7'd0, e.e_vv});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [7:0] a_irr, input logic [7:0] a_imr, input logic a_inta,
                                input logic a_eoi, input logic a_esp, input logic [2:0] a_elev,
                                input logic [4:0] a_vb, input logic x_int, input logic [7:0] x_clr,
                                input logic [7:0] x_isr, input logic [7:0] x_vec, input logic x_vv);
        tbl.push_back('{a_irr, a_imr, a_inta, a_eoi, a_esp, a_elev, a_vb,
                        x_int, x_clr, x_isr, x_vec, x_vv});
    endfunction

    initial begin
        //   irr    imr    inta eoi esp lvl  vb     int clr    isr    vec    vv
        add(8'h08, 8'h00, 0, 0, 0, 3'd0, 5'd1,  1, 8'h00, 8'h00, 8'h00, 0);  // 0
        add(8'h08, 8'h00, 1, 0, 0, 3'd0, 5'd1,  0, 8'h08, 8'h08, 8'h00, 0);
        add(8'h00, 8'h00, 1, 0, 0, 3'd0, 5'd1,  0, 8'h00, 8'h08, 8'h0B, 1);
        add(8'h00, 8'h00, 0, 0, 0, 3'd0, 5'd1,  0, 8'h00, 8'h08, 8'h0B, 0);
        add(8'h02, 8'h00, 0, 0, 0, 3'd0, 5'd1,  1, 8'h00, 8'h08, 8'h0B, 0);  // nest
        add(8'h02, 8'h00, 1, 0, 0, 3'd0, 5'd1,  0, 8'h02, 8'h0A, 8'h0B, 0);
        add(8'h00, 8'h00, 1, 0, 0, 3'd0, 5'd1,  0, 8'h00, 8'h0A, 8'h09, 1);
        add(8'h10, 8'h00, 0, 0, 0, 3'd0, 5'd1,  0, 8'h00, 8'h0A, 8'h09, 0);  // blocked
        add(8'h10, 8'h00, 0, 1, 0, 3'd0, 5'd1,  0, 8'h00, 8'h08, 8'h09, 0);
        add(8'h10, 8'h00, 0, 1, 0, 3'd0, 5'd1,  0, 8'h00, 8'h00, 8'h09, 0);
        add(8'h10, 8'h00, 0, 0, 0, 3'd0, 5'd1,  1, 8'h00, 8'h00, 8'h09, 0);  // 10
        add(8'h10, 8'h00, 1, 0, 0, 3'd0, 5'd1,  0, 8'h10, 8'h10, 8'h09, 0);
        add(8'h00, 8'h00, 1, 0, 0, 3'd0, 5'd1,  0, 8'h00, 8'h10, 8'h0C, 1);
        add(8'h00, 8'h00, 0, 1, 1, 3'd4, 5'd1,  0, 8'h00, 8'h00, 8'h0C, 0);
        add(8'h00, 8'h00, 0, 1, 1, 3'd4, 5'd1,  0, 8'h00, 8'h00, 8'h0C, 0);
        add(8'h00, 8'h00, 0, 1, 0, 3'd0, 5'd1,  0, 8'h00, 8'h00, 8'h0C, 0);
        add(8'h24, 8'h04, 0, 0, 0, 3'd0, 5'd2,  1, 8'h00, 8'h00, 8'h0C, 0);  // masked winner
        add(8'h24, 8'h04, 1, 0, 0, 3'd0, 5'd2,  0, 8'h20, 8'h20, 8'h0C, 0);
        add(8'h04, 8'h04, 1, 0, 0, 3'd0, 5'd2,  0, 8'h00, 8'h20, 8'h15, 1);
        add(8'h00, 8'h00, 0, 1, 1, 3'd5, 5'd2,  0, 8'h00, 8'h00, 8'h15, 0);
        add(8'h01, 8'h00, 0, 0, 0, 3'd0, 5'd2,  1, 8'h00, 8'h00, 8'h15, 0);  // 20 spurious
        add(8'h00, 8'h00, 1, 0, 0, 3'd0, 5'd2,  0, 8'h00, 8'h00, 8'h15, 0);
        add(8'h00, 8'h00, 1, 0, 0, 3'd0, 5'd2,  0, 8'h00, 8'h00, 8'h17, 1);
        add(8'h01, 8'h00, 0, 0, 0, 3'd0, 5'd2,  1, 8'h00, 8'h00, 8'h17, 0);
        add(8'h01, 8'h00, 1, 0, 0, 3'd0, 5'd2,  0, 8'h01, 8'h01, 8'h17, 0);
        add(8'h02, 8'h00, 0, 0, 0, 3'd0, 5'd2,  0, 8'h00, 8'h01, 8'h17, 0);  // ACK1 wait
        add(8'h02, 8'h00, 0, 0, 0, 3'd0, 5'd2,  0, 8'h00, 8'h01, 8'h17, 0);
        add(8'h00, 8'h00, 1, 0, 0, 3'd0, 5'd3,  0, 8'h00, 8'h01, 8'h18, 1);
        add(8'h00, 8'h00, 1, 0, 0, 3'd0, 5'd3,  0, 8'h00, 8'h01, 8'h18, 0);  // inta in IDLE
        add(8'h00, 8'h00, 0, 1, 0, 3'd0, 5'd3,  0, 8'h00, 8'h00, 8'h18, 0);
        add(8'h04, 8'h00, 0, 0, 0, 3'd0, 5'd3,  1, 8'h00, 8'h00, 8'h18, 0);  // 30 set wins
        add(8'h04, 8'h00, 1, 1, 1, 3'd2, 5'd3,  0, 8'h04, 8'h04, 8'h18, 0);
        add(8'h00, 8'h00, 1, 0, 0, 3'd0, 5'd3,  0, 8'h00, 8'h04, 8'h1A, 1);
        add(8'h00, 8'h00, 0, 1, 1, 3'd2, 5'd3,  0, 8'h00, 8'h00, 8'h1A, 0);
        add(8'h08, 8'h00, 0, 0, 0, 3'd0, 5'd3,  1, 8'h00, 8'h00, 8'h1A, 0);  // withdrawn
        add(8'h00, 8'h00, 0, 0, 0, 3'd0, 5'd3,  0, 8'h00, 8'h00, 8'h1A, 0);
        add(8'h08, 8'h08, 0, 0, 0, 3'd0, 5'd3,  0, 8'h00, 8'h00, 8'h1A, 0);  // masked

        // Reset values while reset is held.
        #2;
        chk("rst_int_out", -1, {7'd0, int_out0}, 8'h00);
        chk("rst_isr",     -1, isr0, 8'h00);
        chk("rst_vector",  -1, vec0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].irr, tbl[i].imr, tbl[i].inta, tbl[i].eoi, tbl[i].esp, tbl[i].elev, tbl[i].vb);
            sb.push_back('{i, tbl[i].e_int, tbl[i].e_clr, tbl[i].e_isr, tbl[i].e_vec, tbl[i].e_vv});
            clock_and_score();
        end

        // Reset asserted while in ACK1 with clear_irr and isr active.
        drive(8'h08, 8'h00, 0, 0, 0, 3'd0, 5'd1);
        tick();
        drive(8'h08, 8'h00, 1, 0, 0, 3'd0, 5'd1);
        tick();
        chk("pre_rst_isr", 100, isr0, 8'h08);
        drive(8'h00, 8'h00, 0, 0, 0, 3'd0, 5'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_int_out",   101, {7'd0, int_out0}, 8'h00);
        chk("arst_clear_irr", 101, clr0, 8'h00);
        chk("arst_isr",       101, isr0, 8'h00);
        chk("arst_vector",    101, vec0, 8'h00);
        chk("arst_vv",        101, {7'd0, vv0}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h00, 8'h00, 1, 0, 0, 3'd0, 5'd1);
        tick();
        chk("post_rst_vv",     102, {7'd0, vv0}, 8'h00);
        chk("post_rst_vector", 102, vec0, 8'h00);
        drive(8'h00, 8'h00, 0, 0, 0, 3'd0, 5'd1);
        tick();
        chk("post_rst_vv2", 103, {7'd0, vv0}, 8'h00);

        // Auto-EOI instance.
        drive(8'h40, 8'h00, 0, 0, 0, 3'd0, 5'd3);
        tick();
        chk("ae_int_out", 200, {7'd0, int_out1}, 8'h01);
        drive(8'h40, 8'h00, 1, 0, 0, 3'd0, 5'd3);
        tick();
        chk("ae_isr1",  201, isr1, 8'h40);
        chk("ae_clr1",  201, clr1, 8'h40);
        drive(8'h00, 8'h00, 1, 0, 0, 3'd0, 5'd3);
        tick();
        chk("ae_isr2",  202, isr1, 8'h00);
        chk("ae_vec",   202, vec1, 8'h1E);
        chk("ae_vv",    202, {7'd0, vv1}, 8'h01);
        drive(8'h04, 8'h00, 0, 0, 0, 3'd0, 5'd3);
        tick();
        drive(8'h04, 8'h00, 1, 0, 0, 3'd0, 5'd3);
        tick();
        chk("ae_isr3",  203, isr1, 8'h04);
        drive(8'h00, 8'h00, 0, 1, 1, 3'd2, 5'd3);
        tick();
        chk("ae_spec_eoi", 204, isr1, 8'h00);
        drive(8'h00, 8'h00, 1, 0, 0, 3'd0, 5'd3);
        tick();
        chk("ae_vec2",  205, vec1, 8'h1A);
        chk("ae_vv2",   205, {7'd0, vv1}, 8'h01);
        chk("ae_isr4",  205, isr1, 8'h00);
        drive(8'h00, 8'h00, 0, 0, 0, 3'd0, 5'd3);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
